regfile_dumper: RTL and testbench

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper_pkg.sv | 11 +
 rtl/register_file.sv | 25 ++
 rtl/regfile_dumper.sv | 95 +++++++++
 tb/tb_regfile_dumper.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dumper_pkg.sv
// rtl/regfile_dumper_pkg.sv - shared FSM state type for the register file dumper
package regfile_dumper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - register file with one write port and one combinational read port, register 0 reads zero
module register_file #(
  parameter  int Nreg  = 32,
  parameter  int Dbits = 32,
  localparam int Aw    = (Nreg > 1) ? $clog2(Nreg) : 1
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [Aw-1:0]    i_waddr,
  input  logic [Dbits-1:0] i_wdata,
  input  logic [Aw-1:0]    i_raddr,
  output logic [Dbits-1:0] o_rdata
);

  logic [Dbits-1:0] r_mem [Nreg];

  always_ff @(posedge i_clock) begin
    if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr == '0) ? '0 : r_mem[i_raddr];

endmodule

// File: rtl/regfile_dumper.sv
// rtl/regfile_dumper.sv - walks a register file read port and streams every register out with a valid/ready handshake
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter  int Nreg  = 32,
  parameter  int Dbits = 32,
  localparam int Aw    = (Nreg > 1) ? $clog2(Nreg) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [Aw-1:0]    rd_addr,
  input  logic [Dbits-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Dbits-1:0] out_data,
  output logic [Aw-1:0]    out_addr,
  output logic             out_last
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Nreg - 1);

  state_t           r_state;
  logic [Aw-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_out_valid;
  logic [Dbits-1:0] r_out_data;
  logic [Aw-1:0]    r_out_addr;
  logic             r_out_last;
  logic             w_last_cnt;

  assign w_last_cnt = (r_cnt == LastAddr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // rd_addr is the counter itself, so rd_data already belongs to this word
          r_out_data  <= rd_data;
          r_out_addr  <= r_cnt;
          r_out_last  <= w_last_cnt;
          r_out_valid <= 1'b1;
          r_state     <= SEND;
        end
        SEND: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_last_cnt) begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= LOAD;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_addr   = r_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_regfile_dumper.sv
// tb/tb_regfile_dumper.sv - scoreboard bench for regfile_dumper attached to a register_file read port
module tb_regfile_dumper;

  localparam int NREG  = 32;
  localparam int DBITS = 32;
  localparam int AW    = 5;

  localparam int SC_BASIC = 0;
  localparam int SC_BP    = 1;
  localparam int SC_BUSY  = 2;
  localparam int SC_RST   = 3;
  localparam int SC_WR    = 4;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [DBITS-1:0] data;
    logic             last;
  } word_t;

  logic             clock     = 1'b0;
  logic             reset_n   = 1'b0;
  logic             start     = 1'b0;
  logic             out_ready = 1'b0;
  logic             rf_we     = 1'b0;
  logic [AW-1:0]    rf_waddr  = '0;
  logic [DBITS-1:0] rf_wdata  = '0;
  logic             busy, done, out_valid, out_last;
  logic [AW-1:0]    rd_addr, out_addr;
  logic [DBITS-1:0] rd_data, out_data;

  word_t            exp_q[$];
  word_t            mon_e;
  logic [DBITS-1:0] mem_model [NREG];
  logic [DBITS-1:0] dump_log  [NREG];
  logic [DBITS-1:0] prev_log  [NREG];
  int               n_checks = 0;
  int               n_errors = 0;
  logic             prev_stall = 1'b0;
  logic [DBITS-1:0] prev_data;
  logic [AW-1:0]    prev_addr;

  register_file #(.Nreg(NREG), .Dbits(DBITS)) u_rf (
    .i_clock (clock),
    .i_we    (rf_we),
    .i_waddr (rf_waddr),
    .i_wdata (rf_wdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  regfile_dumper #(.Nreg(NREG), .Dbits(DBITS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (!out_valid) check("last_without_valid", 64'(out_last), 64'd0);
      if (prev_stall && out_valid) begin
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_addr", 64'(out_addr), 64'(prev_addr));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_addr", 64'(out_addr), 64'(mon_e.addr));
          check("word_data", 64'(out_data), 64'(mon_e.data));
          check("word_last", 64'(out_last), 64'(mon_e.last));
          dump_log[out_addr] = out_data;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_addr  = out_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_log();
    for (int a = 0; a < NREG; a++) dump_log[a] = '1;
  endtask

  // cycles counts edges from the one that samples start to the one entering FIN
  task automatic run_dump(input int scen, output int cycles, output int dones);
    bit fired;
    bit finished;
    int stall;
    fired = 0; finished = 0; stall = 0;
    cycles = -1; dones = 0;
    @(posedge clock); #1;
    start = 1'b1;
    out_ready = 1'b1;
    if (scen == SC_WR) mem_model[20] = 32'hDEAD_BEEF;
    for (int a = 0; a < NREG; a++)
      exp_q.push_back('{addr: AW'(a), data: mem_model[a], last: (a == NREG - 1)});
    for (int i = 0; i < 300 && !finished; i++) begin
      @(posedge clock); #1;
      cycles++;
      start = 1'b0; rf_we = 1'b0; out_ready = 1'b1;
      if (scen == SC_BP && out_valid && out_addr == 5'd3 && !fired) begin
        fired = 1; stall = 7;
      end
      if (stall > 0) begin
        out_ready = 1'b0; stall--;
      end
      if (scen == SC_BUSY && out_valid && out_addr == 5'd10 && !fired) begin
        fired = 1; start = 1'b1;
      end
      if (scen == SC_WR && out_valid && out_addr == 5'd15 && !fired) begin
        fired = 1; rf_we = 1'b1; rf_waddr = 5'd20; rf_wdata = 32'hDEAD_BEEF;
      end
      if (scen == SC_RST && out_valid && out_addr == 5'd12) begin
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        exp_q.delete();
        finished = 1;
      end
      @(negedge clock);
      if (done) begin
        dones++;
        finished = 1;
      end
    end
    if (!finished) check("dump_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle_watch(input int n, output int dn);
    dn = 0;
    repeat (n) begin
      @(negedge clock);
      if (done) dn++;
    end
  endtask

  initial begin
    int cyc, dn, extra;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_last", 64'(out_last), 64'd0);
    check("reset_out_addr", 64'(out_addr), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_rd_addr", 64'(rd_addr), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < NREG; k++) begin
      @(posedge clock); #1;
      rf_we = 1'b1; rf_waddr = AW'(k); rf_wdata = 32'hA000_0000 + k;
      mem_model[k] = (k == 0) ? '0 : 32'hA000_0000 + k;
    end
    @(posedge clock); #1;
    rf_we = 1'b0;

    clear_log();
    run_dump(SC_BASIC, cyc, dn);
    check("basic_cycles", 64'(cyc), 64'd64);
    check("basic_done", 64'(dn), 64'd1);
    check("basic_word0", 64'(dump_log[0]), 64'd0);
    check("basic_word5", 64'(dump_log[5]), 64'hA000_0005);
    check("basic_queue_empty", 64'(exp_q.size()), 64'd0);
    idle_watch(4, extra);
    check("basic_extra_done", 64'(extra), 64'd0);
    check("basic_idle_busy", 64'(busy), 64'd0);

    run_dump(SC_BP, cyc, dn);
    check("bp_cycles", 64'(cyc), 64'd71);
    check("bp_done", 64'(dn), 64'd1);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    idle_watch(2, extra);

    run_dump(SC_BUSY, cyc, dn);
    check("busy_cycles", 64'(cyc), 64'd64);
    check("busy_done", 64'(dn), 64'd1);
    check("busy_queue_empty", 64'(exp_q.size()), 64'd0);
    idle_watch(4, extra);
    check("busy_extra_done", 64'(extra), 64'd0);

    run_dump(SC_RST, cyc, dn);
    check("rst_no_done_before", 64'(dn), 64'd0);
    idle_watch(3, extra);
    check("rst_no_done_held", 64'(extra), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_dump(SC_BASIC, cyc, dn);
    check("after_rst_cycles", 64'(cyc), 64'd64);
    check("after_rst_done", 64'(dn), 64'd1);
    idle_watch(2, extra);

    clear_log();
    run_dump(SC_WR, cyc, dn);
    check("wr_cycles", 64'(cyc), 64'd64);
    check("wr_word20", 64'(dump_log[20]), 64'hDEAD_BEEF);
    check("wr_word19", 64'(dump_log[19]), 64'hA000_0013);
    idle_watch(2, extra);

    clear_log();
    run_dump(SC_BASIC, cyc, dn);
    check("b2b_first_done", 64'(dn), 64'd1);
    for (int a = 0; a < NREG; a++) prev_log[a] = dump_log[a];
    clear_log();
    run_dump(SC_BASIC, cyc, dn);
    check("b2b_second_cycles", 64'(cyc), 64'd64);
    check("b2b_second_done", 64'(dn), 64'd1);
    for (int a = 0; a < NREG; a++) check("b2b_same_word", 64'(dump_log[a]), 64'(prev_log[a]));
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
    idle_watch(2, extra);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
